// File: rtl/j1_boot_pkg.sv
// Shared types and constants for the J1 boot loader: FSM states, frame sync byte
// and the frame length legality check.
package j1_boot_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned LIM_W  = LEN_W + 1;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHECK,
    ST_ERR,
    ST_RUN
  } state_e;

  // A frame must carry at least one word and no more words than code RAM holds.
  function automatic logic len_bad(input logic [LEN_W-1:0] n, input int unsigned aw);
    logic [LIM_W-1:0] lim;
    lim = LIM_W'(1) << aw;
    return (n == '0) || ({1'b0, n} > lim);
  endfunction

endpackage

// File: rtl/j1_boot_csum.sv
// 8-bit modulo-256 payload accumulator with synchronous clear and a compare
// against the received checksum byte.
module j1_boot_csum
  import j1_boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic [BYTE_W-1:0] cmp_i,
  output logic              match_c
);

  logic [BYTE_W-1:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (add_i) begin
      sum_q <= sum_q + byte_i;
    end
  end

  assign match_c = (sum_q == cmp_i);

endmodule

// File: rtl/j1_boot_loader.sv
// Boot sequencer: holds the J1 core in reset, loads a framed image from a byte
// stream into code RAM, verifies its checksum and then releases the core.
module j1_boot_loader
  import j1_boot_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  input  logic              boot_req,
  output logic              cpu_resetq,
  output logic              code_we,
  output logic [ADDR_W-1:0] code_waddr,
  output logic [WIDTH-1:0]  code_wdata,
  output logic              busy,
  output logic              err
);

  state_e              state_q;
  logic                rx_ready_q;
  logic                cpu_resetq_q;
  logic                code_we_q;
  logic [ADDR_W-1:0]   code_waddr_q;
  logic [WIDTH-1:0]    code_wdata_q;
  logic                busy_q;
  logic                err_q;
  logic [BYTE_W-1:0]   len_hi_q;
  logic [BYTE_W-1:0]   hi_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;

  logic                rx_fire_c;
  logic [LEN_W-1:0]    len_c;
  logic                csum_clr_c;
  logic                csum_add_c;
  logic                csum_match_c;

  assign rx_fire_c  = rx_valid & rx_ready_q;
  assign len_c      = {len_hi_q, rx_data};
  assign csum_clr_c = rx_fire_c && (state_q == ST_SYNC) && (rx_data == SYNC_BYTE);
  assign csum_add_c = rx_fire_c && ((state_q == ST_DATA_HI) || (state_q == ST_DATA_LO));

  j1_boot_csum u_csum (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (csum_clr_c),
    .add_i   (csum_add_c),
    .byte_i  (rx_data),
    .cmp_i   (rx_data),
    .match_c (csum_match_c)
  );

  // Frame sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SYNC;
      rx_ready_q   <= 1'b1;
      cpu_resetq_q <= 1'b0;
      code_we_q    <= 1'b0;
      code_waddr_q <= '0;
      code_wdata_q <= '0;
      busy_q       <= 1'b1;
      err_q        <= 1'b0;
      len_hi_q     <= '0;
      hi_q         <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
    end else begin
      code_we_q <= 1'b0;
      case (state_q)
        ST_SYNC: begin
          if (rx_fire_c && (rx_data == SYNC_BYTE)) begin
            state_q <= ST_LEN_HI;
            err_q   <= 1'b0;
            addr_q  <= '0;
          end
        end
        ST_LEN_HI: begin
          if (rx_fire_c) begin
            len_hi_q <= rx_data;
            state_q  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (rx_fire_c) begin
            if (len_bad(len_c, ADDR_W)) begin
              state_q    <= ST_ERR;
              err_q      <= 1'b1;
              rx_ready_q <= 1'b0;
            end else begin
              cnt_q   <= len_c;
              state_q <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (rx_fire_c) begin
            hi_q    <= rx_data;
            state_q <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          // Length check guarantees addr_q only wraps after the final word.
          if (rx_fire_c) begin
            code_we_q    <= 1'b1;
            code_waddr_q <= addr_q;
            code_wdata_q <= WIDTH'({hi_q, rx_data});
            addr_q       <= addr_q + ADDR_W'(1);
            cnt_q        <= cnt_q - LEN_W'(1);
            state_q      <= (cnt_q == LEN_W'(1)) ? ST_CHECK : ST_DATA_HI;
          end
        end
        ST_CHECK: begin
          if (rx_fire_c) begin
            rx_ready_q <= 1'b0;
            if (csum_match_c) begin
              state_q      <= ST_RUN;
              cpu_resetq_q <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          state_q    <= ST_SYNC;
          rx_ready_q <= 1'b1;
        end
        ST_RUN: begin
          if (boot_req) begin
            state_q      <= ST_SYNC;
            rx_ready_q   <= 1'b1;
            cpu_resetq_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_SYNC;
          rx_ready_q   <= 1'b1;
          cpu_resetq_q <= 1'b0;
          busy_q       <= 1'b1;
        end
      endcase
    end
  end

  assign rx_ready   = rx_ready_q;
  assign cpu_resetq = cpu_resetq_q;
  assign code_we    = code_we_q;
  assign code_waddr = code_waddr_q;
  assign code_wdata = code_wdata_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_j1_boot_loader.sv
// Scoreboard bench for j1_boot_loader: expected RAM writes are queued as frames
// are driven and popped by a write monitor; status outputs are checked per phase.
module tb_j1_boot_loader;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          boot_req = 1'b0;
  logic          rx_ready;
  logic          cpu_resetq;
  logic          code_we;
  logic [AW-1:0] code_waddr;
  logic [DW-1:0] code_wdata;
  logic          busy;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [15:0]      img [0:8191];
  logic             prev_we = 1'b0;
  int               nwrites = 0;
  logic [AW-1:0]    last_waddr = '0;

  j1_boot_loader #(.WIDTH(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .boot_req   (boot_req),
    .cpu_resetq (cpu_resetq),
    .code_we    (code_we),
    .code_waddr (code_waddr),
    .code_wdata (code_wdata),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: each strobe is a single cycle and matches the oldest queued write.
  always @(negedge clk) begin
    if (code_we) begin
      expect_eq("we_single_cycle", 32'(prev_we), 32'd0);
      expect_eq("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        expect_eq("waddr", 32'(code_waddr), 32'(e[AW+DW-1:DW]));
        expect_eq("wdata", 32'(code_wdata), 32'(e[DW-1:0]));
      end
      nwrites    <= nwrites + 1;
      last_waddr <= code_waddr;
    end
    prev_we <= code_we;
  end

  task automatic send(input logic [7:0] b, input int max_gap);
    int gap;
    int n;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom());
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) expect_eq("rx_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] len, input int nw, input logic [7:0] csum_add,
                            input int max_gap, input bit boot_in_data);
    logic [7:0] sum;
    sum = 8'h00;
    send(8'hA5, max_gap);
    send(len[15:8], max_gap);
    send(len[7:0], max_gap);
    if (boot_in_data) boot_req = 1'b1;
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({AW'(i), img[i]});
      send(img[i][15:8], max_gap);
      send(img[i][7:0], max_gap);
      sum = sum + img[i][15:8] + img[i][7:0];
    end
    boot_req = 1'b0;
    send(sum + csum_add, max_gap);
    idle();
  endtask

  task automatic boot_pulse();
    @(negedge clk);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    expect_eq("reload_resetq", 32'(cpu_resetq), 32'd0);
    expect_eq("reload_ready", 32'(rx_ready), 32'd1);
    expect_eq("reload_busy", 32'(busy), 32'd1);
  endtask

  task automatic expect_running(input string tag);
    expect_eq({tag, "_resetq"}, 32'(cpu_resetq), 32'd1);
    expect_eq({tag, "_busy"}, 32'(busy), 32'd0);
    expect_eq({tag, "_err"}, 32'(err), 32'd0);
    expect_eq({tag, "_ready"}, 32'(rx_ready), 32'd0);
  endtask

  task automatic bad_len(input logic [15:0] len, input string tag);
    int w0;
    w0 = nwrites;
    send(8'hA5, 0);
    send(len[15:8], 0);
    send(len[7:0], 0);
    idle();
    expect_eq({tag, "_err"}, 32'(err), 32'd1);
    expect_eq({tag, "_resetq"}, 32'(cpu_resetq), 32'd0);
    @(negedge clk);
    expect_eq({tag, "_resync"}, 32'(rx_ready), 32'd1);
    expect_eq({tag, "_nowrite"}, 32'(nwrites - w0), 32'd0);
  endtask

  initial begin
    int w0;
    // Reset values
    repeat (2) @(negedge clk);
    expect_eq("rst_resetq", 32'(cpu_resetq), 32'd0);
    expect_eq("rst_we", 32'(code_we), 32'd0);
    expect_eq("rst_waddr", 32'(code_waddr), 32'd0);
    expect_eq("rst_wdata", 32'(code_wdata), 32'd0);
    expect_eq("rst_busy", 32'(busy), 32'd1);
    expect_eq("rst_err", 32'(err), 32'd0);
    expect_eq("rst_ready", 32'(rx_ready), 32'd1);
    reset = 1'b0;

    // Good two-word load
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    send_frame(16'h0002, 2, 8'h00, 0, 1'b0);
    expect_running("good");

    // Reload, then the same frame with a corrupt checksum
    boot_pulse();
    send_frame(16'h0002, 2, 8'h01, 0, 1'b0);
    expect_eq("badcs_err", 32'(err), 32'd1);
    expect_eq("badcs_resetq", 32'(cpu_resetq), 32'd0);
    expect_eq("badcs_busy", 32'(busy), 32'd1);
    @(negedge clk);
    expect_eq("badcs_resync", 32'(rx_ready), 32'd1);
    expect_eq("badcs_err_sticky", 32'(err), 32'd1);

    // Garbage before sync, random stalls within the frame
    send(8'h00, 2);
    send(8'hFF, 2);
    send(8'h5A, 2);
    for (int i = 0; i < 6; i++) img[i] = 16'($urandom());
    send_frame(16'h0006, 6, 8'h00, 3, 1'b0);
    expect_running("stall");

    // boot_req held through the data phase is ignored
    boot_pulse();
    for (int i = 0; i < 4; i++) img[i] = 16'(16'h0F0F ^ (i * 16'h1111));
    send_frame(16'h0004, 4, 8'h00, 1, 1'b1);
    expect_running("bootdata");

    // Length limits
    boot_pulse();
    bad_len(16'h0000, "len0");
    bad_len(16'h2001, "len2001");

    // Full-size image
    for (int i = 0; i < 8192; i++) img[i] = 16'((i * 16'h9E37) ^ 16'h5AA5);
    w0 = nwrites;
    send_frame(16'h2000, 8192, 8'h00, 0, 1'b0);
    expect_running("full");
    expect_eq("full_count", 32'(nwrites - w0), 32'd8192);
    expect_eq("full_last_addr", 32'(last_waddr), 32'h1FFF);

    // Reset after the third payload byte
    boot_pulse();
    img[0] = 16'h1234;
    exp_q.push_back({AW'(0), img[0]});
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'hAB, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
    #1;
    expect_eq("midrst_resetq", 32'(cpu_resetq), 32'd0);
    expect_eq("midrst_we", 32'(code_we), 32'd0);
    expect_eq("midrst_err", 32'(err), 32'd0);
    expect_eq("midrst_ready", 32'(rx_ready), 32'd1);
    expect_eq("midrst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    img[0] = 16'hC0DE;
    img[1] = 16'hBEEF;
    send_frame(16'h0002, 2, 8'h00, 0, 1'b0);
    expect_running("afterrst");

    repeat (3) @(negedge clk);
    expect_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
